// File: rtl/convert_fixed_to_float.sv
// Sequential converter from signed Q6.26 fixed point to IEEE-754 single
// precision. The magnitude is normalised one bit per clock, so latency
// depends on the operand's leading-zero count. The mantissa is truncated
// and never rounded.
module convert_fixed_to_float (
   input  logic        CLK,
   input  logic        RST_FF,
   input  logic        Begin_FSM_FF,
   input  logic [31:0] FIXED,
   output logic [31:0] FLOAT,
   output logic        ACK_FF,
   output logic        BUSY
);

   // Q6.26: the binary point sits 26 bits up, so a value of 1.0 has its
   // leading one at bit 26. After a shift count of L, the leading one is at
   // bit 31. The unbiased exponent is then 31 - L - 26, which gives a biased
   // exponent of 132 - L.
   localparam logic [7:0] EXP_TOP = 8'd132;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ABS  = 3'd1,
      S_NORM = 3'd2,
      S_PACK = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t      state;
   logic [31:0] operand;
   logic [31:0] mag;
   logic [4:0]  shift_cnt;
   logic        sign;
   logic [31:0] float_q;
   logic        ack_q;
   logic        busy_q;

   // Two's-complement negation taken as unsigned. The most negative input,
   // 0x80000000, maps onto itself, which is its correct magnitude (2^31).
   logic [31:0] operand_neg;
   assign operand_neg = (~operand) + 32'd1;

   // Biased exponent for the current shift count. This value stays within
   // 101..132 for every nonzero operand.
   logic [7:0] exp_biased;
   assign exp_biased = EXP_TOP - {3'b000, shift_cnt};

   // Control FSM with datapath. ACK_FF and BUSY are registered from the
   // state being entered, so they track the state exactly.
   always_ff @(posedge CLK or posedge RST_FF) begin
      if (RST_FF) begin
         state     <= S_IDLE;
         operand   <= 32'd0;
         mag       <= 32'd0;
         shift_cnt <= 5'd0;
         sign      <= 1'b0;
         float_q   <= 32'd0;
         ack_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (Begin_FSM_FF) begin
                  operand   <= FIXED;
                  shift_cnt <= 5'd0;
                  state     <= S_ABS;
                  busy_q    <= 1'b1;
                  ack_q     <= 1'b0;
               end else begin
                  busy_q <= 1'b0;
                  ack_q  <= 1'b0;
               end
            end

            S_ABS: begin
               sign <= operand[31];
               mag  <= operand[31] ? operand_neg : operand;
               // A zero operand has no leading one to search for.
               state <= (operand == 32'd0) ? S_PACK : S_NORM;
            end

            S_NORM: begin
               // Because mag is nonzero here, at most 31 shifts can occur
               // and shift_cnt cannot wrap.
               if (mag[31]) begin
                  state <= S_PACK;
               end else begin
                  mag       <= {mag[30:0], 1'b0};
                  shift_cnt <= shift_cnt + 5'd1;
               end
            end

            S_PACK: begin
               // mag is zero only when the operand was zero. That case
               // always packs positive zero.
               if (mag == 32'd0) begin
                  float_q <= 32'd0;
               end else begin
                  float_q <= {sign, exp_biased, mag[30:8]};
               end
               state <= S_DONE;
               ack_q <= 1'b1;
            end

            S_DONE: begin
               // Hold here while the start request remains high. This keeps
               // a level request from starting a second conversion.
               if (!Begin_FSM_FF) begin
                  state  <= S_IDLE;
                  ack_q  <= 1'b0;
                  busy_q <= 1'b0;
               end
            end

            default: begin
               state  <= S_IDLE;
               ack_q  <= 1'b0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign FLOAT  = float_q;
   assign ACK_FF = ack_q;
   assign BUSY   = busy_q;

endmodule

// File: tb/tb_convert_fixed_to_float.sv
// Self-checking bench for convert_fixed_to_float. It uses directed vectors,
// randomized operands against an arithmetic reference model, and
// hand-written sequences for level-held start and asynchronous reset.
module tb_convert_fixed_to_float;

   logic        CLK = 1'b0;
   logic        RST_FF;
   logic        Begin_FSM_FF;
   logic [31:0] FIXED;
   logic [31:0] FLOAT;
   logic        ACK_FF;
   logic        BUSY;

   int total = 0;
   int bad   = 0;

   convert_fixed_to_float dut (
      .CLK          (CLK),
      .RST_FF       (RST_FF),
      .Begin_FSM_FF (Begin_FSM_FF),
      .FIXED        (FIXED),
      .FLOAT        (FLOAT),
      .ACK_FF       (ACK_FF),
      .BUSY         (BUSY)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] fx;
      logic [31:0] fl;
      int          lat;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model. It finds the position of the leading one of |value|,
   // scales the value so that this one lands on bit 23, and keeps 23
   // fraction bits (truncation). The operand equals value * 2^-26.
   task automatic ref_model(input logic [31:0] fx, output logic [31:0] fl, output int lat);
      longint v;
      longint a;
      longint man;
      int     p;
      logic [7:0] e;
      v = longint'($signed(fx));
      a = (v < 0) ? -v : v;
      if (a == 0) begin
         fl  = 32'd0;
         lat = 3;
      end else begin
         p = 0;
         for (int b = 0; b < 33; b++) if (((a >> b) & 64'd1) != 0) p = b;
         e   = 8'(127 + p - 26);
         man = (p >= 23) ? (a >> (p - 23)) : (a << (23 - p));
         fl  = {fx[31], e, man[22:0]};
         lat = 4 + (31 - p);
      end
   endtask

   // This task runs one conversion with a single start pulse. FIXED is
   // scrambled while the design is busy, and FLOAT is checked to hold its
   // old value until the acknowledge.
   task automatic run_conv(input string nm, input logic [31:0] fx,
                           input logic [31:0] exp_fl, input int exp_lat);
      logic [31:0] prev;
      int          lat;
      bit          got;
      bit          hold_ok;
      @(negedge CLK);
      FIXED        = fx;
      Begin_FSM_FF = 1'b1;
      prev         = FLOAT;
      lat          = 0;
      got          = 1'b0;
      hold_ok      = 1'b1;
      for (int n = 1; n <= 60 && !got; n++) begin
         @(posedge CLK);
         @(negedge CLK);
         Begin_FSM_FF = 1'b0;
         FIXED        = $urandom;
         if (ACK_FF) begin
            got = 1'b1;
            lat = n;
         end else if (FLOAT !== prev) begin
            hold_ok = 1'b0;
         end
      end
      chk({nm, " ack_seen"}, 32'(got), 32'd1);
      chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
      chk({nm, " float"}, FLOAT, exp_fl);
      chk({nm, " float_hold"}, 32'(hold_ok), 32'd1);
      @(posedge CLK);
      @(negedge CLK);
      chk({nm, " idle_ack"}, 32'(ACK_FF), 32'd0);
      chk({nm, " idle_busy"}, 32'(BUSY), 32'd0);
      $display("conv %s fixed=%h float=%h exp=%h lat=%0d exp_lat=%0d",
               nm, fx, FLOAT, exp_fl, lat, exp_lat);
   endtask

   initial begin
      logic [31:0] rfl;
      int          rlat;
      logic [31:0] held;
      bit          ok;

      tbl[0] = '{32'h04000000, 32'h3F800000, 9};
      tbl[1] = '{32'hFC000000, 32'hBF800000, 9};
      tbl[2] = '{32'h02000000, 32'h3F000000, 10};
      tbl[3] = '{32'h80000000, 32'hC2000000, 4};
      tbl[4] = '{32'h00000001, 32'h32800000, 35};
      tbl[5] = '{32'h00000000, 32'h00000000, 3};
      tbl[6] = '{32'h04000001, 32'h3F800000, 9};

      // Reset state, checked while the clock is idle.
      RST_FF       = 1'b1;
      Begin_FSM_FF = 1'b0;
      FIXED        = 32'd0;
      #1;
      chk("reset float", FLOAT, 32'd0);
      chk("reset ack", 32'(ACK_FF), 32'd0);
      chk("reset busy", 32'(BUSY), 32'd0);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST_FF = 1'b0;

      // Directed vectors.
      for (int i = 0; i < 7; i++)
         run_conv($sformatf("vec%0d", i), tbl[i].fx, tbl[i].fl, tbl[i].lat);

      // Randomized operands spread across all magnitudes.
      for (int i = 0; i < 150; i++) begin
         logic [31:0] fx;
         fx = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 1) == 1) fx = -fx;
         ref_model(fx, rfl, rlat);
         run_conv($sformatf("rnd%0d", i), fx, rfl, rlat);
      end

      // A start request held high through DONE must produce one conversion
      // only.
      @(negedge CLK);
      FIXED        = 32'hFC000000;
      Begin_FSM_FF = 1'b1;
      ok = 1'b0;
      for (int n = 1; n <= 60 && !ok; n++) begin
         @(posedge CLK);
         @(negedge CLK);
         if (n == 2) FIXED = 32'h04000000;
         if (ACK_FF) ok = 1'b1;
      end
      chk("held ack_seen", 32'(ok), 32'd1);
      ok = 1'b1;
      repeat (6) begin
         @(posedge CLK);
         @(negedge CLK);
         if (!ACK_FF || !BUSY) ok = 1'b0;
      end
      chk("held ack_stays", 32'(ok), 32'd1);
      chk("held float", FLOAT, 32'hBF800000);
      held = FLOAT;
      Begin_FSM_FF = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      chk("drop ack", 32'(ACK_FF), 32'd0);
      chk("drop busy", 32'(BUSY), 32'd0);
      chk("drop float_kept", FLOAT, held);
      $display("seq held_begin float=%h", FLOAT);

      // An asynchronous reset during NORM of 0x00000001 aborts the
      // conversion.
      @(negedge CLK);
      FIXED        = 32'h00000001;
      Begin_FSM_FF = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      Begin_FSM_FF = 1'b0;
      repeat (4) @(posedge CLK);
      @(negedge CLK);
      chk("mid busy_before", 32'(BUSY), 32'd1);
      #1 RST_FF = 1'b1;
      #1;
      chk("mid rst float", FLOAT, 32'd0);
      chk("mid rst ack", 32'(ACK_FF), 32'd0);
      chk("mid rst busy", 32'(BUSY), 32'd0);
      RST_FF = 1'b0;
      ok = 1'b1;
      repeat (40) begin
         @(posedge CLK);
         @(negedge CLK);
         if (ACK_FF || BUSY) ok = 1'b0;
      end
      chk("mid no_ack_after", 32'(ok), 32'd1);
      $display("seq mid_reset float=%h", FLOAT);
      run_conv("after_rst", 32'h04000000, 32'h3F800000, 9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog that stops the run if the bench hangs.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/convert_fixed_to_float.md
CONVERT_FIXED_TO_FLOAT -- requirements
Module: convert_fixed_to_float

Interface
REQ-001 Parameters: none; fixed-point format is hard-wired to 32-bit two's complement Q6.26 (26 fraction bits); output is IEEE-754 single precision.
REQ-002 CLK  input  1  system clock; all state changes on rising edge.
REQ-003 RST_FF  input  1  reset, asynchronous, active-high.
REQ-004 Begin_FSM_FF  input  1  start request, level, sampled only in IDLE.
REQ-005 FIXED  input  32  signed Q6.26 operand, sampled on the start edge only.
REQ-006 FLOAT  output  32  registered IEEE-754 result {sign, exp[7:0], mant[22:0]}.
REQ-007 ACK_FF  output  1  conversion complete, high exactly while in DONE.
REQ-008 BUSY  output  1  high in every state except IDLE.

Function
REQ-009 States: IDLE, ABS, NORM, PACK, DONE; encoding is free; any unused encoding SHALL return to IDLE on the next edge.
REQ-010 IDLE: when Begin_FSM_FF=1, capture FIXED into the operand register, clear shift counter L, go to ABS; otherwise stay.
REQ-011 ABS: sign <= operand[31]; mag <= sign ? two's-complement negation of operand : operand, as 32-bit unsigned; go to PACK if operand==0, else NORM.
REQ-012 Most-negative input 0x80000000 SHALL yield mag=0x80000000 (no overflow; unsigned interpretation).
REQ-013 NORM: if mag[31]==0, mag <= mag<<1 and L <= L+1, stay; if mag[31]==1, go to PACK; exactly one bit shifted per cycle.
REQ-014 L is 5 bits; maximum value reached is 31; it SHALL never wrap.
REQ-015 PACK, nonzero operand: FLOAT <= {sign, 8'd132 - L, mag[30:8]}; go to DONE.
REQ-016 PACK, zero operand: FLOAT <= 0x00000000 (positive zero, never 0x80000000); go to DONE.
REQ-017 Mantissa SHALL be truncated toward zero in magnitude (mag[7:0] discarded, no rounding); exponent never underflows or overflows for this format (range 101..132).
REQ-018 DONE: ACK_FF=1; return to IDLE on the first edge with Begin_FSM_FF=0; stay while Begin_FSM_FF=1.
REQ-019 Latency, counting the IDLE edge that samples Begin_FSM_FF as edge 1: ACK_FF rises after edge L+4 for nonzero input (L = leading zeros of mag), after edge 3 for zero input.
REQ-020 FLOAT SHALL hold its value from PACK until the next PACK; it is unchanged in IDLE, ABS and NORM.
REQ-021 Begin_FSM_FF and FIXED changes while BUSY=1 SHALL be ignored (no restart, no operand recapture).
REQ-022 A Begin_FSM_FF held high continuously SHALL NOT start a second conversion: DONE holds until it drops.

Reset
REQ-023 RST_FF=1 SHALL force immediately, independent of CLK: state IDLE, FLOAT=0x00000000, ACK_FF=0, BUSY=0, L=0, mag=0, sign=0, operand=0.
REQ-024 RST_FF asserted mid-conversion SHALL abort it; after release, no ACK_FF until a new Begin_FSM_FF is sampled in IDLE.

Verification
REQ-025 FIXED=0x04000000 (1.0), Begin pulse -> ACK_FF after edge 9, FLOAT=0x3F800000.
REQ-026 FIXED=0xFC000000 (-1.0) -> FLOAT=0xBF800000; FIXED=0x02000000 (0.5) -> FLOAT=0x3F000000, ACK after edge 10.
REQ-027 FIXED=0x80000000 (-32.0) -> ACK after edge 4, FLOAT=0xC2000000; FIXED=0x00000001 -> ACK after edge 35, FLOAT=0x32800000.
REQ-028 FIXED=0x00000000 -> ACK after edge 3, FLOAT=0x00000000; FIXED=0x04000001 -> FLOAT=0x3F800000 (truncation).
REQ-029 Begin held high through DONE -> ACK stays high, one conversion only; Begin drop -> IDLE next edge, ACK low, FLOAT retained.
REQ-030 RST_FF pulsed during NORM of 0x00000001 -> ACK_FF=0, BUSY=0, FLOAT=0 immediately; next Begin with 0x04000000 -> 0x3F800000 after edge 9.
